// File: rtl/riscv_lsu_pkg.sv
// Shared LSU configuration: data width, funct3 encodings, error codes, FSM states
// and the request legality helpers used at acceptance time.
package riscv_lsu_pkg;
    localparam int XLEN = 32;

    // Stores reuse the low three codes: SB = LB, SH = LH, SW = LW.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_ILLEGAL  = 2'b11
    } lsu_err_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
        logic bad;
        if (we) bad = (funct3 > F3_LW);
        else    bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        return bad;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        case (funct3[1:0])
            2'b01:   bad = addr_lo[0];
            2'b10:   bad = (addr_lo != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction
endpackage

// File: rtl/riscv_lsu_align.sv
// Combinational lane alignment: byte enables, replicated store data and
// shifted, sign/zero-extended load data.
module riscv_lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);
    logic [XLEN-1:0] shifted;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch can be inferred.
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        o_rdata = i_rdata;
        shifted = i_rdata >> {i_addr_lo, 3'b000};

        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                o_be    = 4'b0011 << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase

        case (i_funct3)
            F3_LB:   o_rdata = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            F3_LH:   o_rdata = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            F3_LBU:  o_rdata = {{(XLEN-8){1'b0}}, shifted[7:0]};
            F3_LHU:  o_rdata = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: o_rdata = i_rdata;
        endcase
    end
endmodule

// File: rtl/riscv_lsu.sv
// RV32I load/store unit: accepts one request at a time, checks legality and
// alignment, runs a single data-memory handshake with optional timeout.
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_lsu_valid,
    output logic            o_lsu_ready,
    input  logic            i_lsu_we,
    input  logic [2:0]      i_lsu_funct3,
    input  logic [XLEN-1:0] i_lsu_addr,
    input  logic [XLEN-1:0] i_lsu_wdata,
    output logic            o_lsu_done,
    output logic [XLEN-1:0] o_lsu_rdata,
    output logic [1:0]      o_lsu_err,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [3:0]      o_dmem_be,
    output logic [XLEN-1:0] o_dmem_wdata,
    input  logic            i_dmem_ack,
    input  logic [XLEN-1:0] i_dmem_rdata
);
    lsu_state_e      state_q, state_d;
    lsu_err_e        err_q, err_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [31:0]     cnt_q, cnt_d;

    logic [3:0]      lane_be;
    logic [XLEN-1:0] lane_wdata, load_data;
    logic            busy, timeout_hit;

    riscv_lsu_align u_align (
        .i_funct3  (funct3_q),
        .i_addr_lo (addr_q[1:0]),
        .i_wdata   (wdata_q),
        .i_rdata   (i_dmem_rdata),
        .o_be      (lane_be),
        .o_wdata   (lane_wdata),
        .o_rdata   (load_data)
    );

    assign busy        = (state_q == ST_BUSY);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (i_lsu_valid) begin
                    we_d     = i_lsu_we;
                    funct3_d = i_lsu_funct3;
                    addr_d   = i_lsu_addr;
                    wdata_d  = i_lsu_wdata;
                    cnt_d    = '0;
                    if (f3_illegal(i_lsu_we, i_lsu_funct3)) begin
                        err_d   = ERR_ILLEGAL;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end else if (f3_misaligned(i_lsu_funct3, i_lsu_addr[1:0])) begin
                        err_d   = ERR_MISALIGN;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // Ack is checked first so an ack in the last allowed cycle still succeeds.
                if (i_dmem_ack) begin
                    err_d   = ERR_NONE;
                    rdata_d = we_q ? '0 : load_data;
                    state_d = ST_DONE;
                end else if (timeout_hit) begin
                    err_d   = ERR_TIMEOUT;
                    rdata_d = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q  <= ST_IDLE;
            err_q    <= ERR_NONE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q  <= state_d;
            err_q    <= err_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
        end
    end

    // Memory outputs are gated by BUSY so they read as zero whenever no request is live.
    assign o_lsu_ready  = (state_q == ST_IDLE);
    assign o_lsu_done   = (state_q == ST_DONE);
    assign o_lsu_rdata  = rdata_q;
    assign o_lsu_err    = err_q;
    assign o_dmem_req   = busy;
    assign o_dmem_we    = busy & we_q;
    assign o_dmem_addr  = busy ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign o_dmem_be    = busy ? lane_be : 4'b0000;
    assign o_dmem_wdata = busy ? lane_wdata : '0;
endmodule

// File: tb/tb_riscv_lsu.sv
// Self-checking bench for riscv_lsu: directed scenarios plus randomized
// transactions compared against a byte-level memory model.
module tb_riscv_lsu;
    import riscv_lsu_pkg::*;

    localparam int TMO = 4;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_lsu_valid = 1'b0;
    logic        o_lsu_ready;
    logic        i_lsu_we = 1'b0;
    logic [2:0]  i_lsu_funct3 = 3'b000;
    logic [31:0] i_lsu_addr = '0;
    logic [31:0] i_lsu_wdata = '0;
    logic        o_lsu_done;
    logic [31:0] o_lsu_rdata;
    logic [1:0]  o_lsu_err;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [31:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack = 1'b0;
    logic [31:0] i_dmem_rdata = '0;

    always #5 i_clk = ~i_clk;

    riscv_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_lsu_valid  (i_lsu_valid),
        .o_lsu_ready  (o_lsu_ready),
        .i_lsu_we     (i_lsu_we),
        .i_lsu_funct3 (i_lsu_funct3),
        .i_lsu_addr   (i_lsu_addr),
        .i_lsu_wdata  (i_lsu_wdata),
        .o_lsu_done   (o_lsu_done),
        .o_lsu_rdata  (o_lsu_rdata),
        .o_lsu_err    (o_lsu_err),
        .o_dmem_req   (o_dmem_req),
        .o_dmem_we    (o_dmem_we),
        .o_dmem_addr  (o_dmem_addr),
        .o_dmem_be    (o_dmem_be),
        .o_dmem_wdata (o_dmem_wdata),
        .i_dmem_ack   (i_dmem_ack),
        .i_dmem_rdata (i_dmem_rdata)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] mem [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: sizes in bytes, lanes enumerated explicitly.
    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [1:0] ref_check(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'b11;
        if ((addr % acc_size(f3)) != 0) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] addr);
        logic [3:0] be;
        int off, n;
        off = int'(addr % 4);
        n = acc_size(f3);
        for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + n);
        return be;
    endfunction

    function automatic logic [31:0] ref_lanes(input logic [2:0] f3, input logic [31:0] wdata);
        logic [31:0] w;
        int n;
        n = acc_size(f3);
        for (int i = 0; i < 4; i++) w[8*i +: 8] = wdata[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word);
        longint v;
        int off, n;
        off = int'(addr % 4);
        n = acc_size(f3);
        v = 0;
        for (int k = 0; k < n; k++) v = v | (longint'(word[8*(off+k) +: 8]) << (8*k));
        if (!f3[2] && n < 4 && v[8*n-1]) v = v - (longint'(1) << (8*n));
        return v[31:0];
    endfunction

    task automatic do_txn(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata, input int ack_after);
        logic [1:0]  e_err;
        logic [31:0] e_rdata;
        int          e_req, n_req, lat;
        bit          done_seen;
        int          idx;
        logic [3:0]  e_be;
        logic [31:0] e_lanes;

        idx     = int'(addr[5:2]);
        e_err   = ref_check(we, f3, addr);
        e_be    = ref_be(f3, addr);
        e_lanes = ref_lanes(f3, wdata);
        e_req   = 0;
        if (e_err == 2'b00) begin
            e_req = (ack_after <= TMO) ? ack_after : TMO;
            if (ack_after > TMO) e_err = 2'b10;
        end
        e_rdata = (e_err == 2'b00 && !we) ? ref_load(f3, addr, mem[idx]) : 32'h0;

        check({tag, " ready"}, 32'(o_lsu_ready), 32'd1);
        i_lsu_valid  = 1'b1;
        i_lsu_we     = we;
        i_lsu_funct3 = f3;
        i_lsu_addr   = addr;
        i_lsu_wdata  = wdata;
        @(posedge i_clk); #1;
        i_lsu_valid  = 1'b0;
        i_lsu_wdata  = ~wdata;
        i_lsu_addr   = ~addr;

        n_req = 0;
        lat = 1;
        done_seen = 1'b0;
        for (int c = 0; c < 20 && !done_seen; c++) begin
            i_dmem_ack = 1'b0;
            if (o_lsu_done) begin
                done_seen = 1'b1;
            end else begin
                if (o_dmem_req) begin
                    n_req++;
                    check({tag, " dmem_addr"}, o_dmem_addr, addr & 32'hFFFF_FFFC);
                    check({tag, " dmem_be"}, 32'(o_dmem_be), 32'(e_be));
                    check({tag, " dmem_we"}, 32'(o_dmem_we), 32'(we));
                    if (we) check({tag, " dmem_wdata"}, o_dmem_wdata, e_lanes);
                    if (n_req == ack_after) begin
                        i_dmem_ack   = 1'b1;
                        i_dmem_rdata = mem[idx];
                        if (we)
                            for (int i = 0; i < 4; i++)
                                if (e_be[i]) mem[idx][8*i +: 8] = e_lanes[8*i +: 8];
                    end
                end
                @(posedge i_clk); #1;
                lat++;
            end
        end
        i_dmem_ack = 1'b0;

        check({tag, " done"}, 32'(done_seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(e_req + 1));
        check({tag, " req_cycles"}, 32'(n_req), 32'(e_req));
        check({tag, " err"}, 32'(o_lsu_err), 32'(e_err));
        if (e_err == 2'b00 || e_err == 2'b10) check({tag, " rdata"}, o_lsu_rdata, e_rdata);

        @(posedge i_clk); #1;
        check({tag, " done_1cyc"}, 32'(o_lsu_done), 32'd0);
        check({tag, " err_hold"}, 32'(o_lsu_err), 32'(e_err));
        if (e_err == 2'b00 || e_err == 2'b10) check({tag, " rdata_hold"}, o_lsu_rdata, e_rdata);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = $urandom;

        // Reset state while reset is held.
        #3;
        check("rst ready", 32'(o_lsu_ready), 32'd1);
        check("rst done", 32'(o_lsu_done), 32'd0);
        check("rst req", 32'(o_dmem_req), 32'd0);
        check("rst err", 32'(o_lsu_err), 32'd0);
        check("rst rdata", o_lsu_rdata, 32'h0);
        check("rst dmem", {o_dmem_addr[27:0], o_dmem_be}, 32'h0);
        check("rst wdata", o_dmem_wdata, 32'h0);
        #20 i_rstn = 1'b1;
        @(posedge i_clk); #1;

        // Sign-extended byte load, minimum latency.
        mem[0] = 32'h80FF_1234;
        do_txn("lb_0x103", 1'b0, 3'b000, 32'h103, 32'h0, 1);
        check("lb_0x103 const", o_lsu_rdata, 32'hFFFF_FF80);

        // Halfword store with ack delayed to the third request cycle.
        do_txn("sh_0x202", 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 3);
        check("sh_0x202 mem", mem[0], 32'hABCD_1234);

        // Misaligned word load and illegal store funct3.
        do_txn("lw_0x101", 1'b0, 3'b010, 32'h101, 32'h0, 1);
        check("lw_0x101 const", 32'(o_lsu_err), 32'd1);
        do_txn("st_f3_011", 1'b1, 3'b011, 32'h100, 32'h1234_5678, 1);
        check("st_f3_011 const", 32'(o_lsu_err), 32'd3);

        // Timeout, then an ack in the last allowed cycle.
        do_txn("lw_timeout", 1'b0, 3'b010, 32'h010, 32'h0, 99);
        check("lw_timeout const", 32'(o_lsu_err), 32'd2);
        do_txn("lw_ack_last", 1'b0, 3'b010, 32'h010, 32'h0, TMO);

        // Ack while idle has no effect.
        i_dmem_ack = 1'b1;
        @(posedge i_clk); #1;
        i_dmem_ack = 1'b0;
        check("idle_ack done", 32'(o_lsu_done), 32'd0);
        check("idle_ack ready", 32'(o_lsu_ready), 32'd1);

        // Reset pulse during BUSY drops the transaction.
        mem[0] = 32'h8001_0000;
        i_lsu_valid  = 1'b1;
        i_lsu_we     = 1'b0;
        i_lsu_funct3 = 3'b010;
        i_lsu_addr   = 32'h0;
        @(posedge i_clk); #1;
        i_lsu_valid  = 1'b0;
        check("rstbusy req_before", 32'(o_dmem_req), 32'd1);
        #2 i_rstn = 1'b0;
        #1;
        check("rstbusy req", 32'(o_dmem_req), 32'd0);
        check("rstbusy ready", 32'(o_lsu_ready), 32'd1);
        check("rstbusy err", 32'(o_lsu_err), 32'd0);
        check("rstbusy rdata", o_lsu_rdata, 32'h0);
        #2 i_rstn = 1'b1;
        @(posedge i_clk); #1;
        i_dmem_ack   = 1'b1;
        i_dmem_rdata = 32'hDEAD_BEEF;
        @(posedge i_clk); #1;
        i_dmem_ack   = 1'b0;
        check("rstbusy late_ack done", 32'(o_lsu_done), 32'd0);
        check("rstbusy late_ack rdata", o_lsu_rdata, 32'h0);
        do_txn("lhu_0x002", 1'b0, 3'b101, 32'h002, 32'h0, 1);
        check("lhu_0x002 const", o_lsu_rdata, 32'h0000_8001);

        // Randomized mix of loads, stores, bad encodings, misalignment and timeouts.
        for (int t = 0; t < 60; t++) begin
            logic        r_we;
            logic [2:0]  r_f3;
            logic [31:0] r_addr;
            r_we   = 1'($urandom_range(0, 1));
            r_f3   = 3'($urandom_range(0, 7));
            r_addr = 32'($urandom_range(0, 63));
            do_txn($sformatf("rnd%0d", t), r_we, r_f3, r_addr, $urandom, int'($urandom_range(1, TMO + 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/riscv_lsu.md
RISCV_LSU -- requirements
Module: riscv_lsu

Interface
REQ-001 The block SHALL use parameter TIMEOUT_CYCLES, default 255, giving the maximum number of cycles to wait for memory acknowledge; 0 disables the timeout.
REQ-002 The block SHALL take the data width `XLEN (32) from the shared configs header.
REQ-003 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 i_rstn  in  1  reset, asynchronous, active-low.
REQ-005 i_lsu_valid  in  1  request from execute stage.
REQ-006 o_lsu_ready  out  1  request accepted when valid && ready.
REQ-007 i_lsu_we  in  1  1 = store, 0 = load.
REQ-008 i_lsu_funct3  in  3  access size and sign (RV32I funct3).
REQ-009 i_lsu_addr  in  XLEN  byte address.
REQ-010 i_lsu_wdata  in  XLEN  store data (low bits significant).
REQ-011 o_lsu_done  out  1  one-cycle completion pulse.
REQ-012 o_lsu_rdata  out  XLEN  extended load result, feeding the writeback select mux.
REQ-013 o_lsu_err  out  2  error code: 00 none, 01 misaligned, 10 timeout, 11 illegal funct3.
REQ-014 o_dmem_req / o_dmem_we  out  1 / 1  memory request and direction.
REQ-015 o_dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
REQ-016 o_dmem_be / o_dmem_wdata  out  4 / XLEN  byte enables and lane-replicated store data.
REQ-017 i_dmem_ack / i_dmem_rdata  in  1 / XLEN  acknowledge; rdata valid in the ack cycle.

Function
REQ-018 The FSM SHALL have states IDLE, BUSY and DONE; o_lsu_ready SHALL be 1 only in IDLE.
REQ-019 On acceptance in IDLE, the block SHALL latch we, funct3, addr and wdata.
REQ-020 If funct3 is illegal (load: 011, 110, 111; store: anything other than 000/001/010), the block SHALL go to DONE with err=11 and issue no memory request.
REQ-021 If the access is misaligned (halfword with addr[0]=1, or word with addr[1:0]!=0), the block SHALL go to DONE with err=01 and issue no memory request; an illegal funct3 takes priority.
REQ-022 Otherwise the block SHALL go to BUSY, where o_dmem_req=1 and all dmem outputs stay stable until i_dmem_ack.
REQ-023 On i_dmem_ack in BUSY, the block SHALL register the formatted load data (0 for stores) and go to DONE with err=00.
REQ-024 Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111; these apply to loads and stores alike.
REQ-025 Store data: SB replicates byte 4 times; SH replicates halfword 2 times; SW passes data through.
REQ-026 Load data SHALL be shifted right by addr[1:0]*8, then LB/LH sign-extended, LBU/LHU zero-extended, LW passed through.
REQ-027 A BUSY cycle counter SHALL start at 0; if it reaches TIMEOUT_CYCLES-1 without ack, the block SHALL go to DONE with err=10 and o_lsu_rdata=0. An ack in that same cycle wins over the timeout.
REQ-028 DONE SHALL last exactly one cycle with o_lsu_done=1, then return to IDLE.
REQ-029 Minimum latency: accept in cycle N, req in N+1, ack in N+1, done in N+2.
REQ-030 o_lsu_rdata and o_lsu_err SHALL hold their values until the next DONE.
REQ-031 The block SHALL ignore i_dmem_ack outside BUSY, and ignore i_lsu_valid outside IDLE.

Reset
REQ-032 Asserting i_rstn low SHALL immediately force IDLE and set o_dmem_req=0, o_lsu_done=0, o_lsu_rdata=0, o_lsu_err=00, and counter=0; this applies mid-transaction too, and the transaction is dropped.
REQ-033 After reset o_lsu_ready SHALL be 1 and the dmem outputs SHALL be 0.

Structure
REQ-034 The shared configs header SHALL hold the funct3 encodings, error codes and FSM state encodings.
REQ-035 A combinational sub-module riscv_lsu_align SHALL produce byte enables, store lane data and load extraction/extension.

Verification
REQ-036 LB at addr 0x103 with mem word 0x80FF_1234 and ack in the first BUSY cycle -> done at N+2 with rdata=0xFFFF_FF80 and err=00.
REQ-037 SH at 0x202 with wdata 0x0000_ABCD -> be=1100, wdata=0xABCD_ABCD, addr=0x200, and req held for 3 cycles while ack is delayed 3 cycles.
REQ-038 LW at 0x101 -> done at N+1 with err=01 and o_dmem_req never asserted; a store with funct3=011 -> err=11.
REQ-039 TIMEOUT_CYCLES=4 with no ack -> req for 4 cycles, then done with err=10 and rdata=0; a repeat with ack in the 4th cycle -> err=00.
REQ-040 i_rstn pulsed low during BUSY -> req drops asynchronously, a later ack is ignored, and the next LHU at 0x002 of 0x8001_0000 returns 0x0000_8001.
